// File: rtl/rambus_pkg.sv
// rtl/rambus_pkg.sv - shared state encoding, sizing limits and helpers for the RAM bus arbiter
package rambus_pkg;

    localparam int MAX_REQ = 8;
    localparam int ADDR_W  = 10;
    localparam int PTR_W   = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick: first set request after ptr, returned one-hot with a valid flag
module rr_pick
    import rambus_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!valid && req[IDX_W'(idx)]) begin
                gnt[IDX_W'(idx)] = 1'b1;
                valid            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rambus_arbiter.sv
// rtl/rambus_arbiter.sv - round-robin arbiter sharing one wishbone RAM bus among NUM_REQ masters
// Optional stall timeout with forced release: define RAMBUS_ARB_TIMEOUT_EN.
module rambus_arbiter
    import rambus_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [NUM_REQ-1:0]    req_cyc_i,
    input  logic [NUM_REQ-1:0]    req_stb_i,
    input  logic [NUM_REQ-1:0]    req_we_i,
    input  logic [4*NUM_REQ-1:0]  req_sel_i,
    input  logic [32*NUM_REQ-1:0] req_dat_i,
    input  logic [10*NUM_REQ-1:0] req_adr_i,
    output logic [NUM_REQ-1:0]    req_ack_o,
    output logic [31:0]           req_dat_o,
    output logic                  rambus_wb_clk_o,
    output logic                  rambus_wb_rst_o,
    output logic                  rambus_wb_stb_o,
    output logic                  rambus_wb_cyc_o,
    output logic                  rambus_wb_we_o,
    output logic [3:0]            rambus_wb_sel_o,
    output logic [31:0]           rambus_wb_dat_o,
    output logic [ADDR_W-1:0]     rambus_wb_adr_o,
    input  logic                  rambus_wb_ack_i,
    input  logic [31:0]           rambus_wb_dat_i,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic                  timeout_o
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("rambus_arbiter: parameter out of range");
    end

    arb_state_t          state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    owner;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic                pick_valid;
    logic                owner_hold;
    logic                busy;
    logic [ADDR_W-1:0]   adr_full;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_cyc_i),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    assign busy       = (state == ST_BUSY);
    assign owner_hold = |(grant_q & req_cyc_i);
    assign grant_o    = grant_q;

`ifdef RAMBUS_ARB_TIMEOUT_EN
    logic [7:0] stall_cnt;
    logic       timeout_q;
    assign timeout_o = timeout_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            ptr       <= PTR_W'(NUM_REQ - 1);
            owner     <= '0;
            grant_q   <= '0;
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    stall_cnt <= '0;
                    if (pick_valid) begin
                        grant_q <= pick_gnt;
                        owner   <= onehot_to_idx(MAX_REQ'(pick_gnt));
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!owner_hold) begin
                        ptr       <= owner;
                        grant_q   <= '0;
                        stall_cnt <= '0;
                        state     <= ST_GAP;
                    end else if (rambus_wb_ack_i) begin
                        stall_cnt <= '0;
                    end else if (rambus_wb_stb_o) begin
                        // Count reaching the limit on this edge releases the owner without an ack.
                        if (stall_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                            ptr       <= owner;
                            grant_q   <= '0;
                            stall_cnt <= '0;
                            timeout_q <= 1'b1;
                            state     <= ST_GAP;
                        end else begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign timeout_o = 1'b0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            ptr     <= PTR_W'(NUM_REQ - 1);
            owner   <= '0;
            grant_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_gnt;
                        owner   <= onehot_to_idx(MAX_REQ'(pick_gnt));
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!owner_hold) begin
                        ptr     <= owner;
                        grant_q <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif

    // Grant is one-hot, so OR-ing the gated lanes is a mux onto the shared bus.
    always_comb begin
        rambus_wb_stb_o = 1'b0;
        rambus_wb_cyc_o = 1'b0;
        rambus_wb_we_o  = 1'b0;
        rambus_wb_sel_o = '0;
        rambus_wb_dat_o = '0;
        adr_full        = '0;
        if (busy) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_q[i]) begin
                    rambus_wb_stb_o = rambus_wb_stb_o | req_stb_i[i];
                    rambus_wb_cyc_o = rambus_wb_cyc_o | req_cyc_i[i];
                    rambus_wb_we_o  = rambus_wb_we_o  | req_we_i[i];
                    rambus_wb_sel_o = rambus_wb_sel_o | req_sel_i[i*4 +: 4];
                    rambus_wb_dat_o = rambus_wb_dat_o | req_dat_i[i*32 +: 32];
                    adr_full        = adr_full        | req_adr_i[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    assign rambus_wb_adr_o = adr_full & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign req_ack_o       = busy ? (grant_q & {NUM_REQ{rambus_wb_ack_i}}) : '0;
    assign req_dat_o       = rambus_wb_dat_i;
    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = wb_rst_i;

endmodule

// File: doc/rambus_arbiter.md
RAMBUS_ARBITER -- requirements
Module: rambus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the RAM bus, legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles without ack before forced release, legal range 1..255.
REQ-003 SHALL have port wb_clk_i  in  1: the only clock.
REQ-004 SHALL have port wb_rst_i  in  1: reset, synchronous, active-high.
REQ-005 SHALL have ports req_cyc_i, req_stb_i, req_we_i  in  NUM_REQ each: per-requester wishbone cycle, strobe and write enable.
REQ-006 SHALL have ports req_sel_i  in  4*NUM_REQ, req_dat_i  in  32*NUM_REQ, req_adr_i  in  10*NUM_REQ: packed per-requester select, write data and byte address.
REQ-007 SHALL have port req_ack_o  out  NUM_REQ: per-requester ack.
REQ-008 SHALL have port req_dat_o  out  32: read data, broadcast to all requesters.
REQ-009 SHALL have ports rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_stb_o, rambus_wb_cyc_o, rambus_wb_we_o  out  1 each; rambus_wb_sel_o  out  4; rambus_wb_dat_o  out  32; rambus_wb_adr_o  out  10: shared RAM master bus.
REQ-010 SHALL have ports rambus_wb_ack_i  in  1 and rambus_wb_dat_i  in  32: RAM response.
REQ-011 SHALL have ports grant_o  out  NUM_REQ (one-hot or zero current owner) and timeout_o  out  1 (one-cycle pulse on forced release).

Function
REQ-012 SHALL implement states IDLE, BUSY and GAP.
REQ-013 In IDLE, with any req_cyc_i high, SHALL register a grant to the first requester with cyc high, searching round-robin from index ptr+1, and SHALL enter BUSY on the next cycle.
REQ-014 In BUSY, SHALL drive rambus stb, cyc, we, sel and dat combinationally from the granted requester, and SHALL drive rambus_wb_adr_o as that requester's adr[9:2] concatenated with 2'b00.
REQ-015 SHALL route rambus_wb_ack_i combinationally only to the granted requester's req_ack_o bit; all other ack bits SHALL be 0.
REQ-016 SHALL drive req_dat_o equal to rambus_wb_dat_i at all times.
REQ-017 SHALL keep the grant while the owner holds req_cyc_i high, so that multi-beat bursts are never interrupted by another requester.
REQ-018 When the owner drops req_cyc_i, SHALL set ptr to the owner index, clear grant_o, and enter GAP for exactly one cycle before returning to IDLE.
REQ-019 When no grant is held (IDLE, GAP), SHALL drive all rambus outputs except clk and rst to 0.
REQ-020 SHALL drive rambus_wb_clk_o = wb_clk_i and rambus_wb_rst_o = wb_rst_i.
REQ-021 If requests arrive simultaneously, SHALL resolve them by round-robin order only; a requester that releases and re-requests SHALL wait behind every other pending requester.
REQ-022 A requester dropping req_cyc_i while not granted SHALL have no effect.

Reset
REQ-023 While wb_rst_i is high at a clock edge, SHALL go to IDLE, set ptr = NUM_REQ-1 (so requester 0 wins first), clear grant_o and timeout_o, and zero the timeout counter.
REQ-024 A reset during BUSY SHALL drop the grant on the next edge, with no ack delivered after that edge.

Configuration
REQ-025 With macro RAMBUS_ARB_TIMEOUT_EN defined, SHALL count BUSY cycles in which rambus_wb_stb_o is high and rambus_wb_ack_i is low, and SHALL clear the count on every ack.
REQ-026 When that count reaches TIMEOUT_CYCLES, SHALL release the grant, pulse timeout_o, set ptr to the owner index and enter GAP; the timed-out requester SHALL receive no ack.
REQ-027 Without RAMBUS_ARB_TIMEOUT_EN, SHALL contain no counter, SHALL tie timeout_o to 0, and SHALL hold a grant indefinitely.

Structure
REQ-028 State encoding, the NUM_REQ maximum and the address width (10) SHALL live in shared package rambus_pkg.
REQ-029 The round-robin priority pick SHALL be a sub-module rr_pick, taking a request vector and ptr and returning a one-hot grant plus a valid flag.

Verification
REQ-030 Reset, then req 2 cyc/stb write adr 0x0F3 -> grant_o=0b0100 after 1 cycle; rambus_wb_adr_o=0x0F0; ack reaches only req_ack_o[2].
REQ-031 Reqs 0,1,3 assert cyc together from reset -> served in order 0,1,3, each grant separated by one GAP cycle.
REQ-032 Req 1 holds cyc for a 4-beat burst while req 0 waits -> no grant switch until req 1 drops cyc; req 0 is granted after GAP.
REQ-033 With RAMBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, RAM never acks -> timeout_o pulses after 8 stalled cycles; grant passes to the next pending requester.
REQ-034 wb_rst_i asserted mid-burst -> grant_o=0 and all rambus control outputs 0 on the next edge; requester 0 wins the next arbitration.
